// File: rtl/cpu_mem_model.sv
// Cycle-level CPU memory model: mirrored RAM cleared after reset, preloadable ROM,
// open-bus reads of unmapped space and a configurable number of wait states.
module cpu_mem_model #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RAM_DEPTH   = 2048,
  parameter int unsigned MIRROR_TOP  = 'h1FFF,
  parameter int unsigned ROM_BASE    = 'h8000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr_out,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic              rom_we,
  input  logic [ADDR_W-1:0] rom_waddr,
  input  logic [DATA_W-1:0] rom_wdata
);

  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam int unsigned ROM_DEPTH = (2 ** ADDR_W) - ROM_BASE;
  localparam int unsigned ROM_AW    = $clog2(ROM_DEPTH);
  localparam int unsigned CNT_W     = 3;

  localparam logic [ADDR_W-1:0] MIRROR_A   = ADDR_W'(MIRROR_TOP);
  localparam logic [ADDR_W-1:0] ROM_BASE_A = ADDR_W'(ROM_BASE);
  localparam logic [RAM_AW-1:0] CLR_LAST   = RAM_AW'(RAM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  WS_INIT    = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e              state_q;
  logic [RAM_AW-1:0]   clr_idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   data_in_q;
  logic                ready_q;
  logic                err_q;
  logic                busy_q;

  logic [DATA_W-1:0]   ram [RAM_DEPTH];
  logic [DATA_W-1:0]   rom [ROM_DEPTH];

  logic                ram_hit_c;
  logic                rom_hit_c;
  logic [RAM_AW-1:0]   ram_idx_c;
  logic [ROM_AW-1:0]   rom_idx_c;
  logic [ROM_AW-1:0]   rom_widx_c;
  logic                rom_wok_c;

  // RAM takes priority if the two windows were ever configured to overlap.
  always_comb begin
    ram_hit_c  = (addr_q <= MIRROR_A);
    rom_hit_c  = !ram_hit_c && (addr_q >= ROM_BASE_A);
    ram_idx_c  = addr_q[RAM_AW-1:0];
    rom_idx_c  = ROM_AW'(addr_q - ROM_BASE_A);
    rom_widx_c = ROM_AW'(rom_waddr - ROM_BASE_A);
    rom_wok_c  = (rom_waddr >= ROM_BASE_A);
  end

  // Storage arrays carry no reset: RAM is scrubbed by CLEAR, ROM survives reset.
  always_ff @(posedge clk) begin : ram_write
    if (state_q == ST_CLEAR) begin
      ram[clr_idx_q] <= '0;
    end else if (state_q == ST_RESP && wen_q && ram_hit_c) begin
      ram[ram_idx_c] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin : rom_preload
    if (rom_we && rom_wok_c) begin
      rom[rom_widx_c] <= rom_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      data_in_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == CLR_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (req) begin
            addr_q  <= addr_out;
            wen_q   <= wen;
            wdata_q <= data_out;
            cnt_q   <= WS_INIT;
            state_q <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Access completes here; unmapped reads leave data_in as an open bus.
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
          if (wen_q) begin
            err_q <= rom_hit_c;
          end else if (ram_hit_c) begin
            data_in_q <= ram[ram_idx_c];
          end else if (rom_hit_c) begin
            data_in_q <= rom[rom_idx_c];
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign data_in = data_in_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule
